// File: rtl/bottomhalf_bus_core.sv
// Host-bus bottom half: synchronises the asynchronous host strobes and turns
// their edges into one-cycle payload write/read pulses. It also serves a small
// set of internal ID/status registers at 8'hFC..8'hFF and runs a microsecond
// delay counter.
//
// Ports:
//   __osc, __rst_n       clock, synchronous active-low reset
//   ale, write, read     raw host strobes (read active-low)
//   data_in / data_out   host data bus, with data_oe as the output enable
//   wr_stb/addr/data     one-cycle payload write
//   rd_stb/addr, rd_data one-cycle payload read; rd_data answers combinationally
//   dly_start, dly_usec  delay request; busy is high while the delay runs
module bottomhalf_bus_core #(
  parameter logic [15:0] TYPE        = 16'h0000,
  parameter logic [7:0]  SUBTYPE     = 8'h00,
  parameter int unsigned ADDR_OK_BIT = 4,
  parameter int unsigned CLK_MHZ     = 24,
  parameter int unsigned DLY_W       = 17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             __osc,
  input  logic             __rst_n,
  input  logic             ale,
  input  logic             write,
  input  logic             read,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             data_oe,
  output logic             wr_stb,
  output logic [7:0]       wr_addr,
  output logic [7:0]       wr_data,
  output logic             rd_stb,
  output logic [7:0]       rd_addr,
  input  logic [7:0]       rd_data,
  input  logic             dly_start,
  input  logic [11:0]      dly_usec,
  output logic             busy
);

  // Product width: wide enough for CLK_MHZ * 4095 and for the 2^DLY_W limit.
  localparam int unsigned PW = (DLY_W + 8 > 44) ? DLY_W + 8 : 44;

  logic [SYNC_STAGES-1:0] ale_sync_q, ale_sync_d;
  logic [SYNC_STAGES-1:0] write_sync_q, write_sync_d;
  logic [SYNC_STAGES-1:0] read_sync_q, read_sync_d;
  logic ale_prev_q, write_prev_q, read_prev_q;
  logic ale_s, write_s, read_s;
  logic ale_fall, write_rise, read_fall;

  logic [7:0] addr_q, addr_d;
  logic [7:0] data_out_q, data_out_d;
  logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d, rd_addr_q, rd_addr_d;
  logic       wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;

  logic [DLY_W-1:0] cnt_q, cnt_d, dly_load;
  logic             busy_q, busy_d;
  logic [PW-1:0]    dly_prod, dly_limit;
  logic [7:0]       int_rd_val;

  assign ale_s   = ale_sync_q[SYNC_STAGES-1];
  assign write_s = write_sync_q[SYNC_STAGES-1];
  assign read_s  = read_sync_q[SYNC_STAGES-1];

  assign ale_fall   = ale_prev_q & ~ale_s;
  assign write_rise = ~write_prev_q & write_s;
  assign read_fall  = read_prev_q & ~read_s;

  assign dly_prod  = PW'(CLK_MHZ) * PW'(dly_usec);
  assign dly_limit = PW'(1) << DLY_W;
  assign dly_load  = (dly_prod > dly_limit) ? {DLY_W{1'b1}} : DLY_W'(dly_prod - PW'(1));

  always_comb begin
    int_rd_val = 8'h00;
    unique case (addr_q[1:0])
      2'b00: int_rd_val = {7'b0, busy_q};
      2'b01: int_rd_val = TYPE[7:0];
      2'b10: int_rd_val = TYPE[15:8];
      2'b11: int_rd_val = SUBTYPE;
      default: int_rd_val = 8'h00;
    endcase
  end

  always_comb begin
    ale_sync_d   = {ale_sync_q[SYNC_STAGES-2:0], ale};
    write_sync_d = {write_sync_q[SYNC_STAGES-2:0], write};
    read_sync_d  = {read_sync_q[SYNC_STAGES-2:0], read};
    addr_d     = addr_q;
    data_out_d = data_out_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;

    if (ale_fall) addr_d = data_in;
    // Strobes below use addr_q, so a same-cycle ale edge sees the old address.
    if (write_rise) begin
      wr_stb_d  = 1'b1;
      wr_addr_d = addr_q;
      wr_data_d = data_in;
    end
    // Payload data arrives the cycle after rd_stb.
    if (rd_stb_q) data_out_d = rd_data;
    if (read_fall) begin
      if (&addr_q[7:2]) begin
        data_out_d = int_rd_val;
      end else begin
        rd_stb_d  = 1'b1;
        rd_addr_d = addr_q;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end else if (dly_start && (dly_usec != 12'd0)) begin
      cnt_d  = dly_load;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge __osc) begin
    if (!__rst_n) begin
      ale_sync_q   <= '1;
      write_sync_q <= '1;
      read_sync_q  <= '1;
      ale_prev_q   <= 1'b1;
      write_prev_q <= 1'b1;
      read_prev_q  <= 1'b1;
      addr_q       <= 8'h00;
      data_out_q   <= 8'h00;
      wr_addr_q    <= 8'h00;
      wr_data_q    <= 8'h00;
      rd_addr_q    <= 8'h00;
      wr_stb_q     <= 1'b0;
      rd_stb_q     <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      ale_sync_q   <= ale_sync_d;
      write_sync_q <= write_sync_d;
      read_sync_q  <= read_sync_d;
      ale_prev_q   <= ale_s;
      write_prev_q <= write_s;
      read_prev_q  <= read_s;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      wr_stb_q     <= wr_stb_d;
      rd_stb_q     <= rd_stb_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = ~read & addr_q[ADDR_OK_BIT];
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_stb   = rd_stb_q;
  assign rd_addr  = rd_addr_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bottomhalf_bus_core.sv
module tb_bottomhalf_bus_core;

  localparam int unsigned SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst_n, ale, write, read, dly_start, dly_start_c;
  logic [7:0] data_in, rd_data;
  logic [11:0] dly_usec;
  logic [7:0] data_out, wr_addr, wr_data, rd_addr;
  logic data_oe, wr_stb, rd_stb, busy;
  logic [7:0] c_data_out, c_wr_addr, c_wr_data, c_rd_addr;
  logic c_data_oe, c_wr_stb, c_rd_stb, busy_c;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int busy_cnt = 0;
  int busy_c_cnt = 0;
  int wr_before, rd_before;
  logic [7:0] wr_addr_seen, wr_data_seen, rd_addr_seen;

  always #5 clk = ~clk;

  // Payload responder: a fixed function of the requested address.
  assign rd_data = rd_stb ? (rd_addr ^ 8'h3C) : 8'h00;

  bottomhalf_bus_core #(
    .TYPE(16'hBEEF), .SUBTYPE(8'h5A), .ADDR_OK_BIT(4), .CLK_MHZ(24), .DLY_W(17),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .__osc(clk), .__rst_n(rst_n), .ale(ale), .write(write), .read(read),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_stb(rd_stb), .rd_addr(rd_addr),
    .rd_data(rd_data), .dly_start(dly_start), .dly_usec(dly_usec), .busy(busy)
  );

  // Narrow counter instance for the clamp case.
  bottomhalf_bus_core #(
    .TYPE(16'hBEEF), .SUBTYPE(8'h5A), .ADDR_OK_BIT(4), .CLK_MHZ(24), .DLY_W(10),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut_c (
    .__osc(clk), .__rst_n(rst_n), .ale(1'b1), .write(1'b1), .read(1'b1),
    .data_in(8'h00), .data_out(c_data_out), .data_oe(c_data_oe), .wr_stb(c_wr_stb),
    .wr_addr(c_wr_addr), .wr_data(c_wr_data), .rd_stb(c_rd_stb), .rd_addr(c_rd_addr),
    .rd_data(8'h00), .dly_start(dly_start_c), .dly_usec(dly_usec), .busy(busy_c)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt++;
      wr_addr_seen = wr_addr;
      wr_data_seen = wr_data;
    end
    if (rd_stb) begin
      rd_cnt++;
      rd_addr_seen = rd_addr;
    end
    if (busy) busy_cnt++;
    if (busy_c) busy_c_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic latch_addr(input logic [7:0] a);
    data_in = a;
    ale = 1'b0;
    tick(5);
    ale = 1'b1;
    tick(5);
  endtask

  task automatic do_write(input logic [7:0] d);
    write = 1'b0;
    tick(5);
    data_in = d;
    write = 1'b1;
    tick(5);
  endtask

  task automatic start_delay(input logic [11:0] us);
    busy_cnt = 0;
    dly_usec = us;
    dly_start = 1'b1;
    tick();
    dly_start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit && (busy || busy_c); i++) tick();
    check("wait_idle", {30'b0, busy, busy_c}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; ale = 1'b1; write = 1'b1; read = 1'b1; data_in = 8'h00;
    dly_start = 1'b0; dly_start_c = 1'b0; dly_usec = 12'd0;
    tick(3);
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_strobes", {wr_stb, rd_stb}, 0);
    check("rst_oe", data_oe, 0);

    // ID reads: internal values, no rd_stb.
    rd_before = rd_cnt;
    latch_addr(8'hFD);
    read = 1'b0; tick(5);
    check("id_fd", data_out, 8'hEF);
    check("id_fd_oe", data_oe, 1);
    read = 1'b1; tick(5);
    latch_addr(8'hFE);
    read = 1'b0; tick(5);
    check("id_fe", data_out, 8'hBE);
    read = 1'b1; tick(5);
    latch_addr(8'hFF);
    read = 1'b0; tick(5);
    check("id_ff", data_out, 8'h5A);
    read = 1'b1; tick(5);
    check("id_no_rd_stb", rd_cnt, rd_before);

    // Payload write, plus a write into the internal range.
    wr_before = wr_cnt;
    latch_addr(8'h12);
    do_write(8'hA5);
    check("wr_count", wr_cnt, wr_before + 1);
    check("wr_addr", wr_addr_seen, 8'h12);
    check("wr_data", wr_data_seen, 8'hA5);
    latch_addr(8'hFC);
    do_write(8'h3C);
    check("wr_fc_count", wr_cnt, wr_before + 2);
    check("wr_fc_addr", wr_addr_seen, 8'hFC);

    // Payload read: rd_stb once, data_out = 8'h34 ^ 8'h3C.
    rd_before = rd_cnt;
    latch_addr(8'h34);
    read = 1'b0; tick(5);
    check("rd_count", rd_cnt, rd_before + 1);
    check("rd_addr", rd_addr_seen, 8'h34);
    check("rd_data_out", data_out, 8'h08);
    check("rd_oe", data_oe, 1);
    read = 1'b1; tick(5);
    check("rd_oe_off", data_oe, 0);
    check("rd_hold", data_out, 8'h08);

    // OE gating on the address-valid bit.
    latch_addr(8'h02);
    read = 1'b0; tick(5);
    check("oe_gate_02", data_oe, 0);
    read = 1'b1; tick(5);
    latch_addr(8'h12);
    read = 1'b0; tick(2);
    check("oe_gate_12", data_oe, 1);
    read = 1'b1; tick(1);
    check("oe_gate_12_hi", data_oe, 0);
    tick(5);

    // 10 us delay: 240 cycles, status read during it, retrigger ignored.
    latch_addr(8'hFC);
    start_delay(12'd10);
    check("dly_busy_rise", busy, 1);
    read = 1'b0; tick(5);
    check("status_busy", data_out, 8'h01);
    read = 1'b1; tick(5);
    tick(89);
    dly_usec = 12'd10;
    dly_start = 1'b1; tick(); dly_start = 1'b0;
    wait_idle(400);
    check("dly_240", busy_cnt, 240);
    read = 1'b0; tick(5);
    check("status_idle", data_out, 8'h00);
    read = 1'b1; tick(5);

    // Boundaries: 1 us -> 24 cycles; 0 us -> no-op.
    start_delay(12'd1);
    wait_idle(100);
    check("dly_24", busy_cnt, 24);
    start_delay(12'd0);
    tick(3);
    check("dly_zero", busy_cnt, 0);

    // Clamp: 24*100 = 2400 > 2^10, so 1024 cycles.
    busy_c_cnt = 0;
    dly_usec = 12'd100;
    dly_start_c = 1'b1; tick(); dly_start_c = 1'b0;
    check("clamp_busy_rise", busy_c, 1);
    wait_idle(1300);
    check("clamp_1024", busy_c_cnt, 1024);

    // Reset mid-delay with a write edge still in the synchroniser.
    latch_addr(8'hFD);
    read = 1'b0; tick(5);
    check("pre_rst_data", data_out, 8'hEF);
    read = 1'b1; tick(5);
    start_delay(12'd10);
    tick(38);
    write = 1'b0; tick(5);
    write = 1'b1; tick();
    rst_n = 1'b0;
    wr_before = wr_cnt;
    rd_before = rd_cnt;
    tick(2);
    rst_n = 1'b1;
    tick();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_data", data_out, 8'h00);
    tick(SYNC_STAGES + 3);
    check("rst_no_wr", wr_cnt, wr_before);
    check("rst_no_rd", rd_cnt, rd_before);
    check("rst_still_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
